sha_wr_capture: RTL and testbench
=================================

Name: sha_wr_capture

Overview:
Responder for the 3-bit-address / 32-bit word write interface that feeds the PMU SHA engine.
- Captures eight key words (wc=1) and eight digest words (wc=0) into two 256-bit banks.
- Commits the key on a cs strobe.
- Emits the assembled {key, digest} pair to the downstream SHA/compare logic over a valid/ready handshake.

Parameters:
- WORDS, 8, words per 256-bit bank; fixed by 3-bit address.
- DW, 32, word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- cs  in  1  commit strobe; rising edge with wc=1 commits key bank.
- we  in  1  write enable; level signal, one write per rising edge.
- wc  in  1  bank select; 1 = key bank, 0 = digest bank.
- address  in  3  word index; address k maps to bank bits [32k+31:32k].
- write_data  in  32  write word.
- key_valid  out  1  key bank committed.
- out_valid  out  1  key+digest pair available.
- out_ready  in  1  downstream accepts pair.
- out_key  out  256  committed key.
- out_digest  out  256  captured digest.
- err  out  1  sticky protocol error.

Behaviour:
- Reset: all outputs 0, both banks 0, both 8-bit word masks 0, state KEY. Reset mid-operation discards partial banks immediately.
- we_q registers we. A write fires when we & ~we_q, so a multi-cycle we pulse yields exactly one write.
- cs_q registers cs. A commit fires when cs & ~cs_q.
- Write fired: bank[address] <= write_data and mask[address] <= 1, one cycle after the we edge. Rewriting the same address overwrites data; the mask is unchanged.
- States:
  - KEY: only wc=1 writes are accepted; wc=0 writes set err and are dropped. A commit with key mask == 8'hFF sets key_valid=1 and moves to DIGEST. A commit with an incomplete mask sets err, keeps data, and stays in KEY.
  - DIGEST:
    - wc=0 writes fill the digest bank.
    - wc=1 writes update the key bank and clear key_valid. The block stays in DIGEST and needs a new commit before EMIT; that commit only re-asserts key_valid when the key mask is full.
    - When the digest mask reaches 8'hFF and key_valid=1, the block moves to EMIT on the next cycle.
  - EMIT: out_valid=1. out_key and out_digest are stable and equal to the banks. All writes and commits are dropped and set err. On out_valid & out_ready: out_valid=0, digest mask cleared, key_valid kept, return to DIGEST (key reuse).
- Simultaneous write fire and commit in the same cycle: the write is applied first, and the commit sees the updated mask.
- The 8th digest word and out_ready can never coincide; the EMIT entry has 1-cycle latency. Latency is therefore last digest word we edge -> out_valid = 2 cycles.
- err is sticky and is cleared only by rst.

Optional Feature:
- SHA_CAP_KEY_LOCK_EN
  - Defined: once key_valid first asserts, the key bank is write-protected until rst. wc=1 writes set err and are dropped; commits are ignored.
  - Undefined: key rewrite in DIGEST as described above.

Decomposition:
- Package sha_cap_pkg holds:
  - state enum {KEY, DIGEST, EMIT}
  - localparams WORDS, DW, BANK_W=256
  - function word_slice(addr)
- One sub-module, sha_cap_bank: an 8x32 register bank with valid mask, write port and clear. It is instantiated twice (key, digest).

Test Plan:
- Key load: write 8 words with wc=1, key 256'hff484953ff484953495354480123456789abcdef0123456789abcdef00000006 (addr0 = 32'h00000006), then pulse cs. Required: key_valid=1, out_key equals that value, err=0.
- Digest load after key: 8 wc=0 words, digest 256'h4c4e4953...6c6e6973. Required: out_valid=1 exactly 2 cycles after the 8th we edge, with out_digest equal to that value. Hold out_ready=0 for 5 cycles: out_valid and data stay stable. Then out_ready=1 for one cycle: out_valid=0, state DIGEST.
- Commit with 7 key words loaded (addr7 missing). Required: err=1, key_valid=0. Write addr7, commit again: key_valid=1.
- we held high for 4 cycles with address=3, data 32'hDEADBEEF. Required: a single write, mask bit3 set. Second write of 32'h12345678 to addr3: data overwritten, mask unchanged.
- Assert rst mid-digest after 4 words. Required: all outputs 0 and masks 0. A new full sequence then completes normally.
- With SHA_CAP_KEY_LOCK_EN defined, a wc=1 write after commit. Required: err=1, out_key unchanged. Without the macro: key_valid=0 until recommit.

Source files
------------

// File: rtl/sha_cap_pkg.sv
// Shared widths, FSM state type and word-slice helper for the SHA write-capture block.
package sha_cap_pkg;

    localparam int unsigned WORDS  = 8;
    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 3;
    localparam int unsigned BANK_W = WORDS * DW;

    typedef enum logic [1:0] {
        KEY    = 2'd0,
        DIGEST = 2'd1,
        EMIT   = 2'd2
    } state_e;

    // LSB position of word 'addr' inside a 256-bit bank.
    function automatic int unsigned word_slice(input logic [AW-1:0] addr);
        return 32'(addr) * DW;
    endfunction

endpackage

// File: rtl/sha_wr_capture_if.sv
// Word-write bus plus key/digest output handshake for sha_wr_capture.
interface sha_wr_capture_if;
    import sha_cap_pkg::*;

    logic              cs;
    logic              we;
    logic              wc;
    logic [AW-1:0]     address;
    logic [DW-1:0]     write_data;
    logic              key_valid;
    logic              out_valid;
    logic              out_ready;
    logic [BANK_W-1:0] out_key;
    logic [BANK_W-1:0] out_digest;
    logic              err;

    modport master (
        output cs, we, wc, address, write_data, out_ready,
        input  key_valid, out_valid, out_key, out_digest, err
    );

    modport slave (
        input  cs, we, wc, address, write_data, out_ready,
        output key_valid, out_valid, out_key, out_digest, err
    );

endinterface

// File: rtl/sha_cap_bank.sv
// 8 x 32-bit register bank with a per-word written mask and a mask clear.
module sha_cap_bank
    import sha_cap_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              clr,
    output logic [BANK_W-1:0] data,
    output logic [WORDS-1:0]  mask
);

    // Store the word and mark it present; a write in the same cycle as clr survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            mask <= '0;
        end else begin
            if (clr) begin
                mask <= '0;
            end
            if (wr_en) begin
                data[word_slice(wr_addr) +: DW] <= wr_data;
                mask[wr_addr]                   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha_wr_capture.sv
// Captures a 256-bit key and digest from word writes and hands the pair downstream.
// Optional macro SHA_CAP_KEY_LOCK_EN: key bank becomes write-protected once first committed.
module sha_wr_capture
    import sha_cap_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    sha_wr_capture_if.slave  bus
);

    logic              we_q;
    logic              cs_q;
    state_e            state_q, state_d;
    logic              key_valid_q, key_valid_d;
    logic              err_q, err_d;
    logic              wr_fire;
    logic              commit;
    logic              key_wr;
    logic              dig_wr;
    logic              dig_clr;
    logic              key_locked;
    logic [WORDS-1:0]  key_mask;
    logic [WORDS-1:0]  key_mask_upd;
    logic [WORDS-1:0]  dig_mask;
    logic [BANK_W-1:0] key_data;
    logic [BANK_W-1:0] dig_data;

    assign wr_fire = bus.we & ~we_q;
    assign commit  = bus.cs & ~cs_q & bus.wc;

`ifdef SHA_CAP_KEY_LOCK_EN
    // Leaving KEY only happens through a successful commit, so that marks the lock point.
    assign key_locked = (state_q != KEY);
`else
    assign key_locked = 1'b0;
`endif

    // Edge detectors, FSM state and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            cs_q        <= 1'b0;
            state_q     <= KEY;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            we_q        <= bus.we;
            cs_q        <= bus.cs;
            state_q     <= state_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
        end
    end

    // Write routing, commit evaluation and state transitions.
    always_comb begin
        key_wr       = 1'b0;
        dig_wr       = 1'b0;
        dig_clr      = 1'b0;
        state_d      = state_q;
        key_valid_d  = key_valid_q;
        err_d        = err_q;
        key_mask_upd = key_mask;

        unique case (state_q)
            KEY: begin
                if (wr_fire) begin
                    if (bus.wc) key_wr = 1'b1;
                    else        err_d  = 1'b1;
                end
            end
            DIGEST: begin
                if (wr_fire) begin
                    if (bus.wc) begin
                        if (key_locked) begin
                            err_d = 1'b1;
                        end else begin
                            key_wr      = 1'b1;
                            key_valid_d = 1'b0;
                        end
                    end else begin
                        dig_wr = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (wr_fire || commit) err_d = 1'b1;
                if (bus.out_ready) begin
                    dig_clr = 1'b1;
                    state_d = DIGEST;
                end
            end
            default: state_d = KEY;
        endcase

        // The commit must see a word written in the same cycle.
        if (key_wr) key_mask_upd[bus.address] = 1'b1;

        if (commit && (state_q != EMIT) && !key_locked) begin
            if (&key_mask_upd) begin
                key_valid_d = 1'b1;
                if (state_q == KEY) state_d = DIGEST;
            end else begin
                err_d = 1'b1;
            end
        end

        // A key rewrite in this cycle invalidates the key, so hold off emission.
        if ((state_q == DIGEST) && (&dig_mask) && key_valid_q && !key_wr) begin
            state_d = EMIT;
        end
    end

    sha_cap_bank u_key (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (key_wr),
        .wr_addr (bus.address),
        .wr_data (bus.write_data),
        .clr     (1'b0),
        .data    (key_data),
        .mask    (key_mask)
    );

    sha_cap_bank u_dig (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (dig_wr),
        .wr_addr (bus.address),
        .wr_data (bus.write_data),
        .clr     (dig_clr),
        .data    (dig_data),
        .mask    (dig_mask)
    );

    assign bus.key_valid  = key_valid_q;
    assign bus.out_valid  = (state_q == EMIT);
    assign bus.out_key    = key_data;
    assign bus.out_digest = dig_data;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_sha_wr_capture.sv
// Self-checking bench for sha_wr_capture: directed test-plan scenarios plus random traffic,
// compared every cycle against a word-array reference model.
module tb_sha_wr_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    sha_wr_capture_if bus ();

    sha_wr_capture dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain word arrays, presence flags and a phase number
    // (0 = gathering key, 1 = gathering digest, 2 = presenting pair).
    logic [31:0] m_key [8];
    logic [31:0] m_dig [8];
    bit          m_km  [8];
    bit          m_dm  [8];
    int          m_phase    = 0;
    bit          m_kv       = 0;
    bit          m_err      = 0;
    bit          m_we_prev  = 0;
    bit          m_cs_prev  = 0;

    function automatic logic [255:0] flat(input bit dig);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = dig ? m_dig[i] : m_key[i];
        return r;
    endfunction

    function automatic bit all_set(input bit dig);
        for (int i = 0; i < 8; i++) if (!(dig ? m_dm[i] : m_km[i])) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit wf, cf, go, locked;
        int a;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_key[i] = '0; m_dig[i] = '0; m_km[i] = 0; m_dm[i] = 0;
            end
            m_phase = 0; m_kv = 0; m_err = 0; m_we_prev = 0; m_cs_prev = 0;
        end else begin
            wf = bus.we && !m_we_prev;
            cf = bus.cs && !m_cs_prev && bus.wc;
            m_we_prev = bus.we;
            m_cs_prev = bus.cs;
            a = int'(bus.address);
`ifdef SHA_CAP_KEY_LOCK_EN
            locked = (m_phase != 0);
`else
            locked = 0;
`endif
            go = (m_phase == 1) && all_set(1) && m_kv;
            if (m_phase == 2) begin
                if (wf || cf) m_err = 1;
                if (bus.out_ready) begin
                    m_phase = 1;
                    for (int i = 0; i < 8; i++) m_dm[i] = 0;
                end
            end else begin
                if (wf) begin
                    if (bus.wc) begin
                        if (locked) m_err = 1;
                        else begin
                            m_key[a] = bus.write_data;
                            m_km[a]  = 1;
                            if (m_phase == 1) begin m_kv = 0; go = 0; end
                        end
                    end else if (m_phase == 0) begin
                        m_err = 1;
                    end else begin
                        m_dig[a] = bus.write_data;
                        m_dm[a]  = 1;
                    end
                end
                if (cf && !locked) begin
                    if (all_set(0)) begin
                        m_kv = 1;
                        if (m_phase == 0) m_phase = 1;
                    end else begin
                        m_err = 1;
                    end
                end
                if (go) m_phase = 2;
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_key_valid", 256'(bus.key_valid), 256'(m_kv));
        check("cyc_out_valid", 256'(bus.out_valid), 256'(m_phase == 2));
        check("cyc_err", 256'(bus.err), 256'(m_err));
        check("cyc_out_key", bus.out_key, flat(0));
        check("cyc_out_digest", bus.out_digest, flat(1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Later hold cycles present different data so a repeated write would be visible.
    task automatic wr(input logic c, input logic [2:0] a, input logic [31:0] d, input int hold);
        bus.we = 1'b1; bus.wc = c; bus.address = a; bus.write_data = d;
        for (int i = 0; i < hold; i++) begin
            tick();
            bus.write_data = ~d;
        end
        bus.we = 1'b0; bus.write_data = d;
        tick();
    endtask

    task automatic commit_key();
        bus.wc = 1'b1; bus.cs = 1'b1;
        tick();
        bus.cs = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        bus.we = 0; bus.cs = 0; bus.wc = 0; bus.out_ready = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic load(input logic c, input logic [255:0] v);
        for (int i = 0; i < 8; i++) wr(c, 3'(i), v[i*32 +: 32], 1);
    endtask

    logic [255:0] kval;
    logic [255:0] dval;

    initial begin
        kval = 256'hff484953ff484953495354480123456789abcdef0123456789abcdef00000006;
        dval = 256'h4c4e49530badf00d112233445566778899aabbccddeeff0013579bdf6c6e6973;
        bus.cs = 0; bus.we = 0; bus.wc = 0; bus.address = 0; bus.write_data = 0;
        bus.out_ready = 0;
        do_reset();
        check("rst_key_valid", 256'(bus.key_valid), 256'd0);
        check("rst_out_valid", 256'(bus.out_valid), 256'd0);
        check("rst_err", 256'(bus.err), 256'd0);
        check("rst_out_key", bus.out_key, 256'd0);

        // Key load and commit.
        load(1'b1, kval);
        check("key_word0", bus.out_key[31:0], 256'h6);
        commit_key();
        check("key_valid_after_commit", 256'(bus.key_valid), 256'd1);
        check("key_value", bus.out_key, kval);
        check("key_err", 256'(bus.err), 256'd0);

        // Digest load, emission latency, back-pressure, accept.
        for (int i = 0; i < 7; i++) wr(1'b0, 3'(i), dval[i*32 +: 32], 1);
        bus.we = 1'b1; bus.wc = 1'b0; bus.address = 3'd7; bus.write_data = dval[255:224];
        tick();
        bus.we = 1'b0;
        check("emit_lat1", 256'(bus.out_valid), 256'd0);
        tick();
        check("emit_lat2", 256'(bus.out_valid), 256'd1);
        check("emit_digest", bus.out_digest, dval);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 256'(bus.out_valid), 256'd1);
            check("hold_digest", bus.out_digest, dval);
            check("hold_key", bus.out_key, kval);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("accept_valid", 256'(bus.out_valid), 256'd0);
        check("accept_key_kept", 256'(bus.key_valid), 256'd1);
        check("accept_dig_mask", 256'(dut.u_dig.mask), 256'd0);

        // Commit with addr7 missing.
        do_reset();
        for (int i = 0; i < 7; i++) wr(1'b1, 3'(i), kval[i*32 +: 32], 1);
        commit_key();
        check("partial_err", 256'(bus.err), 256'd1);
        check("partial_kv", 256'(bus.key_valid), 256'd0);
        wr(1'b1, 3'd7, kval[255:224], 1);
        commit_key();
        check("recommit_kv", 256'(bus.key_valid), 256'd1);

        // Long we pulse writes once; rewrite overwrites data only.
        do_reset();
        wr(1'b1, 3'd3, 32'hDEADBEEF, 4);
        check("hold_mask", 256'(dut.u_key.mask), 256'h08);
        check("hold_data", bus.out_key[127:96], 256'hDEADBEEF);
        wr(1'b1, 3'd3, 32'h12345678, 1);
        check("rewrite_mask", 256'(dut.u_key.mask), 256'h08);
        check("rewrite_data", bus.out_key[127:96], 256'h12345678);

        // Reset mid-digest, then a full sequence.
        do_reset();
        load(1'b1, kval);
        commit_key();
        for (int i = 0; i < 4; i++) wr(1'b0, 3'(i), dval[i*32 +: 32], 1);
        rst = 1'b1;
        #1;
        check("midrst_outs", {bus.out_key[252:0], bus.key_valid, bus.out_valid, bus.err}, 256'd0);
        check("midrst_masks", 256'({dut.u_key.mask, dut.u_dig.mask}), 256'd0);
        tick();
        rst = 1'b0;
        tick();
        load(1'b1, dval);
        commit_key();
        load(1'b0, kval);
        for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
        check("rerun_valid", 256'(bus.out_valid), 256'd1);
        check("rerun_pair", bus.out_key ^ bus.out_digest, dval ^ kval);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Key write after commit.
        wr(1'b1, 3'd0, 32'hA5A5A5A5, 1);
`ifdef SHA_CAP_KEY_LOCK_EN
        check("lock_err", 256'(bus.err), 256'd1);
        check("lock_key", bus.out_key, dval);
`else
        check("rekey_kv", 256'(bus.key_valid), 256'd0);
        check("rekey_word", bus.out_key[31:0], 256'hA5A5A5A5);
        commit_key();
        check("rekey_recommit", 256'(bus.key_valid), 256'd1);
`endif

        // Random traffic episodes against the model.
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            load(1'b1, {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom});
            commit_key();
            for (int c = 0; c < 500; c++) begin
                bus.we         = 1'($urandom_range(0, 1));
                bus.wc         = ($urandom_range(0, 4) == 0);
                bus.cs         = ($urandom_range(0, 5) == 0);
                bus.address    = 3'($urandom_range(0, 7));
                bus.write_data = $urandom;
                bus.out_ready  = 1'($urandom_range(0, 1));
                tick();
            end
            bus.we = 0; bus.cs = 0; bus.out_ready = 0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
